// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode FIFO with flush and a fence.i prefetch hold.
module inst_queue #(
    parameter int          DEPTH        = 4,
    parameter int          PTR_BITS     = 2,
    parameter logic [31:0] FENCE_I_INST = 32'h0000100F
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [31:0]         in_inst,
    input  logic [63:0]         in_num,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_inst,
    output logic [63:0]         out_num,
    output logic [PTR_BITS:0]   count,
    output logic                fence_i_done,
    output logic [31:0]         drop_count
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t state, state_next;
    logic [PTR_BITS-1:0] head, tail;
    logic [31:0] pc_mem [DEPTH];
    logic [31:0] inst_mem [DEPTH];
    logic [63:0] num_mem [DEPTH];
    logic enq, deq, fence_enq, fence_deq;

    always_comb begin
        out_valid  = (count != '0) && !flush;
        in_ready   = (count < (PTR_BITS+1)'(DEPTH)) && (state == RUN) && !flush;
        out_pc     = pc_mem[head];
        out_inst   = inst_mem[head];
        out_num    = num_mem[head];
        enq        = in_valid && in_ready;
        deq        = out_valid && out_ready;
        fence_enq  = enq && (in_inst == FENCE_I_INST);
        fence_deq  = deq && (out_inst == FENCE_I_INST);
        state_next = flush ? RUN :
                     (state == RUN && fence_enq) ? HOLD :
                     (state == HOLD && fence_deq) ? RUN : state;
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            pc_mem[tail]   <= in_pc;
            inst_mem[tail] <= in_inst;
            num_mem[tail]  <= in_num;
        end
    end

    // Flush wins over any handshake; it is already masked out of enq/deq.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= RUN;
            fence_i_done <= 1'b0;
            drop_count   <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= RUN;
            fence_i_done <= 1'b0;
            drop_count   <= drop_count + 32'(count);
        end else begin
            head         <= head + PTR_BITS'(deq);
            tail         <= tail + PTR_BITS'(enq);
            count        <= count + (PTR_BITS+1)'(enq) - (PTR_BITS+1)'(deq);
            state        <= state_next;
            fence_i_done <= fence_deq;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and random checks of inst_queue against a queue-based model.
module tb_inst_queue;
    localparam logic [31:0] FENCE = 32'h0000100F;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] num;
    } ent_t;

    logic        clock = 1'b0, reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic [63:0] in_num = '0;
    logic        in_ready, out_valid, fence_i_done;
    logic [31:0] out_pc, out_inst, drop_count;
    logic [63:0] out_num;
    logic [2:0]  count;

    inst_queue dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_num(in_num),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_num(out_num),
        .count(count), .fence_i_done(fence_i_done), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    ent_t        q[$];
    logic        m_hold = 1'b0, m_fdone = 1'b0, acc = 1'b0;
    logic [31:0] m_drop = '0;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v = $urandom;
        return (v == FENCE) ? 32'h00000013 : v;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic ev, er, deq, fd;
        ent_t e;
        #1;
        ev = (q.size() != 0) && !flush;
        er = (q.size() < 4) && !m_hold && !flush;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("count", 64'(count), 64'(q.size()));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        chk("fence_i_done", 64'(fence_i_done), 64'(m_fdone));
        if (ev) begin
            chk("out_pc", 64'(out_pc), 64'(q[0].pc));
            chk("out_inst", 64'(out_inst), 64'(q[0].inst));
            chk("out_num", out_num, q[0].num);
        end
        acc = in_valid && er;
        deq = ev && out_ready;
        if (flush) begin
            m_drop += 32'(q.size());
            q.delete();
            m_hold  = 1'b0;
            m_fdone = 1'b0;
        end else begin
            fd = deq && (q[0].inst == FENCE);
            m_fdone = fd;
            if (deq) void'(q.pop_front());
            if (fd) m_hold = 1'b0;
            if (acc) begin
                e.pc = in_pc; e.inst = in_inst; e.num = in_num;
                q.push_back(e);
                if (in_inst == FENCE) m_hold = 1'b1;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        in_valid = v; in_pc = pc; in_inst = inst; in_num = {$urandom, $urandom};
    endtask

    initial begin
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        step();
        // fill then drain
        for (int i = 0; i < 4; i++) begin drive(1, 32'h80000000 + 32'(4*i), rand_inst()); step(); end
        drive(1, 32'h80000010, rand_inst()); step();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        // streaming
        for (int i = 0; i < 10; i++) begin drive(1, 32'h80000000 + 32'(4*i), rand_inst()); step(); end
        in_valid = 1'b0; step(); step();
        // flush with three entries, then flush an empty queue
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'h90000000 + 32'(4*i), rand_inst()); step(); end
        out_ready = 1'b1; flush = 1'b1; step();
        step();
        flush = 1'b0; in_valid = 1'b0; step();
        // fence hold
        out_ready = 1'b0;
        drive(1, 32'hA0000000, 32'h00000013); step();
        drive(1, 32'hA0000004, FENCE); step();
        drive(1, 32'hA0000008, 32'h00000033);
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0; step(); step();
        // flush during hold
        out_ready = 1'b0;
        drive(1, 32'hB0000000, 32'h00000013); step();
        drive(1, 32'hB0000004, FENCE); step();
        in_valid = 1'b0; step();
        flush = 1'b1; step();
        flush = 1'b0; step(); step();
        // random traffic with stable-until-accepted fetch side
        acc = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc || flush)
                drive(1'($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 5) == 0) ? FENCE : rand_inst());
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        // asynchronous reset with two entries buffered
        flush = 1'b1; in_valid = 1'b0; step();
        flush = 1'b0; out_ready = 1'b0;
        drive(1, 32'hC0000000, rand_inst()); step();
        drive(1, 32'hC0000004, rand_inst()); step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        q.delete(); m_hold = 1'b0; m_fdone = 1'b0; m_drop = '0;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin drive(1, 32'hD0000000 + 32'(4*i), rand_inst()); step(); end
        in_valid = 1'b0; step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling instruction buffer between the instruction fetch unit and the decode unit.
- Accepts fetched {pc, inst, num} triples over a valid/ready handshake and stores them in a DEPTH-entry circular FIFO.
- Presents the oldest entry to decode.
- Supports whole-queue flush on control hazard, and a fence.i hold that stops prefetching past a fence.i until it drains to decode.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- PTR_BITS, 2: log2(DEPTH).
- FENCE_I_INST, 32'h0000100F: encoding that triggers the fence hold.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  control hazard; discard all contents this cycle.
- in_valid  in  1  fetch-side entry valid.
- in_ready  out  1  queue can accept the entry.
- in_pc  in  32  fetched PC.
- in_inst  in  32  fetched instruction.
- in_num  in  64  instruction sequence number.
- out_valid  out  1  head entry valid toward decode.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- out_num  out  64  head sequence number.
- count  out  PTR_BITS+1  current occupancy, 0..DEPTH.
- fence_i_done  out  1  one-cycle registered pulse after fence.i is dequeued.
- drop_count  out  32  cumulative number of entries discarded by flush.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - head = tail = 0, count = 0, state = RUN;
  - fence_i_done = 0, drop_count = 0;
  - out_valid = 0, in_ready = 1 once reset deasserts;
  - storage contents are don't-care.
- Reset asserted mid-operation discards all entries immediately, with no handshake completing.
- Enqueue fires when in_valid && in_ready. On that clock edge, entry[tail] <= {in_pc, in_inst, in_num} and tail <= tail+1 mod DEPTH.
- Dequeue fires when out_valid && out_ready. On that clock edge, head <= head+1 mod DEPTH.
- Pointers wrap modulo DEPTH. Full or empty is determined from count only, never from pointer equality.
- count next value is count + enq - deq. Simultaneous enqueue and dequeue leaves count unchanged.
- Latency:
  - no bypass; an entry enqueued at edge N is visible on out_* from cycle N+1;
  - an empty queue therefore yields out_valid = 0 even while in_valid = 1.
- out_pc, out_inst and out_num are driven combinationally from entry[head]. They are don't-care when out_valid = 0.
- out_valid = (count != 0) && !flush.
- in_ready = (count < DEPTH) && (state == RUN) && !flush.
  - A full queue does not accept in the same cycle it dequeues; in_ready depends on the registered count only.
- State machine:
  - RUN -> HOLD on an enqueue with in_inst == FENCE_I_INST. From the next cycle in_ready = 0, so no instructions are buffered past the fence.
  - HOLD -> RUN on a dequeue with out_inst == FENCE_I_INST. in_ready may rise the following cycle.
  - RUN or HOLD -> RUN on flush.
- fence_i_done is registered: it is 1 in the cycle after any dequeue with out_inst == FENCE_I_INST, otherwise 0.
- flush has priority over all other events:
  - In the flush cycle, in_ready = 0 and out_valid = 0, so no handshake can complete.
  - At the edge, head = tail = 0, count = 0, state = RUN.
  - drop_count <= drop_count + count (pre-flush occupancy), wrapping modulo 2^32.
  - fence_i_done <= 0.
  - Flush of an empty queue leaves drop_count unchanged.
  - Flush held for multiple cycles keeps the queue empty.
- in_valid must stay stable with unchanged data until accepted, except when flush is asserted. Out-of-protocol changes are not detected.

Test Plan:
- Fill and drain:
  - Stimulus: enqueue 4 entries with pc 0x80000000, +4, +8, +C while out_ready = 0.
  - Required: count = 4, in_ready = 0 on the 5th cycle.
  - Then raise out_ready: out_pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C over 4 consecutive cycles, then out_valid = 0, count = 0.
- Streaming:
  - Stimulus: in_valid and out_ready both held 1 for 10 cycles, pc incrementing by 4 from 0x80000000.
  - Required: first out_valid in cycle 1 after the first enqueue; one dequeue per cycle thereafter; count stays at 1; pointers wrap through 0 at least twice with PC order preserved.
- Flush with 3 entries:
  - Stimulus: flush = 1 with 3 entries buffered and out_ready = 1.
  - Required: out_valid = 0 that cycle; next cycle count = 0, drop_count = 3.
  - A second flush on the empty queue leaves drop_count = 3.
- Fence hold:
  - Stimulus: enqueue inst 0x00000013 then 0x0000100F, followed by continuous in_valid.
  - Required: in_ready drops the cycle after the fence is enqueued; count stays at 2.
  - After both entries are dequeued: fence_i_done = 1 for exactly one cycle, and in_ready = 1 again the cycle after the fence dequeue.
- Flush during HOLD:
  - Stimulus: flush asserted while in HOLD with the fence buffered.
  - Required: state returns to RUN, in_ready = 1 the next cycle, fence_i_done remains 0, drop_count increases by the buffered count.
- Asynchronous reset:
  - Stimulus: reset pulsed mid-cycle with 2 entries buffered.
  - Required: out_valid = 0, count = 0 and drop_count = 0 immediately, without waiting for a clock edge; normal enqueue resumes after reset deasserts.
